add_seq_arb: RTL and testbench



---
 rtl/add_seq_pkg.sv | 29 ++
 rtl/add_seq_arb_lf_add8.sv | 72 +++++++
 rtl/add_seq_arb.sv | 172 +++++++++++++++++
 tb/tb_add_seq_arb.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_seq_pkg.sv
// -----------------------------------------------------------------------------
// add_seq_pkg
// Shared types and constants for the add_seq_arb multi-byte add sequencer.
//   state_t    : sequencer FSM state encoding (IDLE, ADD, RESP)
//   BYTE_W     : width of one adder slice step (one byte)
//   idx_width(): bit width of the byte index for a given byte count (>= 1)
// -----------------------------------------------------------------------------
package add_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int BYTE_W = 8;

   // ceil(log2(n)), never less than one bit so a single-byte build still
   // has a legal index register.
   function automatic int idx_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/add_seq_arb_lf_add8.sv
// -----------------------------------------------------------------------------
// lf_add8_cin
// Purely combinational 8-bit Ladner-Fischer parallel-prefix adder with carry-in.
// Ports:
//   a, b  [7:0] : addends
//   cin         : carry into bit 0
//   s     [7:0] : sum
//   cout        : carry out of bit 7
// The carry-in is folded into the bit-0 generate term, so every prefix group
// below already includes cin and directly yields the carry into the next bit.
// -----------------------------------------------------------------------------
module lf_add8_cin (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] s,
   output logic       cout
);

   logic [7:0] p;
   logic [7:0] g;
   logic [8:0] c;

   // Prefix group terms; gXY / pXY cover bits X down to Y.
   logic g0c;
   logic g10, g32, g54, g76;
   logic p32, p54, p76;
   logic g20, g30, g64, g74;
   logic p64, p74;
   logic g40, g50, g60, g70;

   assign p = a ^ b;
   assign g = a & b;

   // Level 0: bit 0 absorbs cin
   assign g0c = g[0] | (p[0] & cin);

   // Level 1: adjacent pairs
   assign g10 = g[1] | (p[1] & g0c);
   assign g32 = g[3] | (p[3] & g[2]);
   assign p32 = p[3] & p[2];
   assign g54 = g[5] | (p[5] & g[4]);
   assign p54 = p[5] & p[4];
   assign g76 = g[7] | (p[7] & g[6]);
   assign p76 = p[7] & p[6];

   // Level 2: groups of four
   assign g20 = g[2] | (p[2] & g10);
   assign g30 = g32  | (p32  & g10);
   assign g64 = g[6] | (p[6] & g54);
   assign p64 = p[6] & p54;
   assign g74 = g76  | (p76  & g54);
   assign p74 = p76  & p54;

   // Level 3: upper half joins the complete lower nibble
   assign g40 = g[4] | (p[4] & g30);
   assign g50 = g54  | (p54  & g30);
   assign g60 = g64  | (p64  & g30);
   assign g70 = g74  | (p74  & g30);

   assign c = {g70, g60, g50, g40, g30, g20, g10, g0c, cin};

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi = gi + 1) begin : g_sum
         assign s[gi] = p[gi] ^ c[gi];
      end
   endgenerate

   assign cout = c[8];

endmodule

// File: rtl/add_seq_arb.sv
// -----------------------------------------------------------------------------
// add_seq_arb
// Two requesters share one 8-bit prefix adder slice through a round-robin
// arbiter. An accepted request adds two 8*NBYTES-bit operands one byte per
// cycle (LSB first) with the carry chained through a register; the result is
// returned on a single response channel tagged with the requester id.
// Optional build macro: ADD_SEQ_OVF_EN adds the resp_ovf signed-overflow port.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   reqN_valid/ready/a/b (N = 0,1)    : request channels
//   resp_valid/ready/id/sum/cout      : response channel
//   resp_ovf                          : signed overflow (ADD_SEQ_OVF_EN only)
// Latency: handshake in cycle T, resp_valid from cycle T+NBYTES+1.
// -----------------------------------------------------------------------------
module add_seq_arb
   import add_seq_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req0_valid,
   output logic                   req0_ready,
   input  logic [8*NBYTES-1:0]    req0_a,
   input  logic [8*NBYTES-1:0]    req0_b,
   input  logic                   req1_valid,
   output logic                   req1_ready,
   input  logic [8*NBYTES-1:0]    req1_a,
   input  logic [8*NBYTES-1:0]    req1_b,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic                   resp_id,
   output logic [8*NBYTES-1:0]    resp_sum,
   output logic                   resp_cout
`ifdef ADD_SEQ_OVF_EN
   ,
   output logic                   resp_ovf
`endif
);

   localparam int W  = BYTE_W * NBYTES;
   localparam int IW = idx_width(NBYTES);
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

   state_t          state_q, state_d;
   logic            last_grant_q, last_grant_d;
   logic            id_q, id_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    sum_q, sum_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            carry_q, carry_d;
   logic            cout_q, cout_d;
`ifdef ADD_SEQ_OVF_EN
   logic            ovf_q, ovf_d;
`endif

   logic            grant0, grant1;
   logic [7:0]      slice_a, slice_b, slice_s;
   logic            slice_cout;

   lf_add8_cin u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry_q),
      .s    (slice_s),
      .cout (slice_cout)
   );

   always_comb begin
      // Arbitration only happens in IDLE; on a tie the requester that did not
      // win last time is granted.
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state_q == IDLE) begin
         grant0 = req0_valid & (~req1_valid |  last_grant_q);
         grant1 = req1_valid & (~req0_valid | ~last_grant_q);
      end

      slice_a = a_q[int'(idx_q)*BYTE_W +: BYTE_W];
      slice_b = b_q[int'(idx_q)*BYTE_W +: BYTE_W];

      state_d      = state_q;
      last_grant_d = last_grant_q;
      id_d         = id_q;
      a_d          = a_q;
      b_d          = b_q;
      sum_d        = sum_q;
      idx_d        = idx_q;
      carry_d      = carry_q;
      cout_d       = cout_q;
`ifdef ADD_SEQ_OVF_EN
      ovf_d        = ovf_q;
`endif

      case (state_q)
         IDLE: begin
            if (grant0 | grant1) begin
               a_d          = grant1 ? req1_a : req0_a;
               b_d          = grant1 ? req1_b : req0_b;
               id_d         = grant1;
               last_grant_d = grant1;
               carry_d      = 1'b0;
               idx_d        = '0;
               state_d      = ADD;
            end
         end
         ADD: begin
            sum_d[int'(idx_q)*BYTE_W +: BYTE_W] = slice_s;
            carry_d = slice_cout;
            idx_d   = idx_q + IW'(1);
            if (idx_q == LAST_IDX) begin
               cout_d  = slice_cout;
`ifdef ADD_SEQ_OVF_EN
               // Same-sign operands whose sum MSB differs from them overflowed.
               ovf_d   = (a_q[W-1] == b_q[W-1]) & (slice_s[7] != a_q[W-1]);
`endif
               state_d = RESP;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         sum_q        <= '0;
         idx_q        <= '0;
         carry_q      <= 1'b0;
         cout_q       <= 1'b0;
`ifdef ADD_SEQ_OVF_EN
         ovf_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         id_q         <= id_d;
         a_q          <= a_d;
         b_q          <= b_d;
         sum_q        <= sum_d;
         idx_q        <= idx_d;
         carry_q      <= carry_d;
         cout_q       <= cout_d;
`ifdef ADD_SEQ_OVF_EN
         ovf_q        <= ovf_d;
`endif
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign resp_valid = (state_q == RESP);
   assign resp_id    = id_q;
   assign resp_sum   = sum_q;
   assign resp_cout  = cout_q;
`ifdef ADD_SEQ_OVF_EN
   assign resp_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_add_seq_arb.sv
// -----------------------------------------------------------------------------
// tb_add_seq_arb
// Self-checking bench for add_seq_arb (NBYTES = 4). Expected sums come from
// plain wide arithmetic; expected grants/timing from a transaction-level model
// (busy flag, last winner, handshake cycle). Define ADD_SEQ_OVF_EN to also
// exercise resp_ovf.
// -----------------------------------------------------------------------------
module tb_add_seq_arb;

   localparam int NB = 4;
   localparam int W  = 8 * NB;

   typedef struct {
      logic         id;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } op_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req0_valid = 1'b0;
   logic          req0_ready;
   logic [W-1:0]  req0_a = '0;
   logic [W-1:0]  req0_b = '0;
   logic          req1_valid = 1'b0;
   logic          req1_ready;
   logic [W-1:0]  req1_a = '0;
   logic [W-1:0]  req1_b = '0;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic          resp_id;
   logic [W-1:0]  resp_sum;
   logic          resp_cout;
`ifdef ADD_SEQ_OVF_EN
   logic          resp_ovf;
`endif

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   logic mdl_last = 1'b1;

   add_seq_arb #(.NBYTES(NB)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_sum   (resp_sum),
      .resp_cout  (resp_cout)
`ifdef ADD_SEQ_OVF_EN
      ,
      .resp_ovf   (resp_ovf)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

`ifdef ADD_SEQ_OVF_EN
   function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
      longint s, maxv, minv;
      maxv = (longint'(1) <<< (W - 1)) - 1;
      minv = -(longint'(1) <<< (W - 1));
      s = longint'($signed(a)) + longint'($signed(b));
      return (s > maxv) || (s < minv);
   endfunction
`endif

   task automatic do_reset();
      rst = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      resp_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      mdl_last = 1'b1;
   endtask

   // Present one request and wait (bounded) for its handshake.
   task automatic send(input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int hs_cyc, output bit ok);
      ok = 1'b0;
      hs_cyc = 0;
      @(negedge clk);
      if (r) begin
         req1_valid = 1'b1; req1_a = a; req1_b = b;
      end else begin
         req0_valid = 1'b1; req0_a = a; req0_b = b;
      end
      for (int i = 0; i < 40; i++) begin
         #1;
         if ((r ? req1_ready : req0_ready) === 1'b1) begin
            ok = 1'b1;
            hs_cyc = cyc;
            break;
         end
         @(negedge clk);
      end
      if (ok) begin
         @(posedge clk);
         #1;
         mdl_last = r;
      end
      // Scramble operands after the handshake: the captured copy must be used.
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_a = $urandom; req0_b = $urandom;
      req1_a = $urandom; req1_b = $urandom;
   endtask

   // Wait (bounded) for a response, capture it and accept it.
   task automatic recv(output bit ok, output int at_cyc, output logic id_o,
                       output logic [W-1:0] sum_o, output logic cout_o, output logic ovf_o);
      ok = 1'b0; at_cyc = 0; id_o = 1'b0; sum_o = '0; cout_o = 1'b0; ovf_o = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (resp_valid === 1'b1) begin
            ok = 1'b1;
            at_cyc = cyc;
            id_o = resp_id;
            sum_o = resp_sum;
            cout_o = resp_cout;
`ifdef ADD_SEQ_OVF_EN
            ovf_o = resp_ovf;
`endif
            break;
         end
      end
      if (ok) begin
         resp_ready = 1'b1;
         @(negedge clk);
         resp_ready = 1'b0;
         $display("txn resp id=%0d sum=%h cout=%0d", id_o, sum_o, cout_o);
      end
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
      n_checks++; if (resp_sum !== '0) begin n_fail++; $display("FAIL reset_resp_sum: got %h expected 0", resp_sum); end
      n_checks++; if (resp_id !== 1'b0) begin n_fail++; $display("FAIL reset_resp_id: got %b expected 0", resp_id); end
      n_checks++; if (resp_cout !== 1'b0) begin n_fail++; $display("FAIL reset_resp_cout: got %b expected 0", resp_cout); end
      n_checks++; if ({req1_ready, req0_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready_idle: got %b expected 00", {req1_ready, req0_ready}); end
`ifdef ADD_SEQ_OVF_EN
      n_checks++; if (resp_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_resp_ovf: got %b expected 0", resp_ovf); end
`endif
      // Tie right after reset must go to requester 0; drop before the edge.
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      n_checks++; if ({req1_ready, req0_ready} !== 2'b01) begin n_fail++; $display("FAIL reset_first_tie: got %b expected 01", {req1_ready, req0_ready}); end
      req0_valid = 1'b0;
      #1;
      n_checks++; if ({req1_ready, req0_ready} !== 2'b10) begin n_fail++; $display("FAIL reset_single_valid: got %b expected 10", {req1_ready, req0_ready}); end
      req1_valid = 1'b0;
      $display("txn reset done");
   endtask

   task automatic test_basic();
      int hs, at; bit ok, rok; logic id, co, ov; logic [W-1:0] s;
      send(1'b0, 32'h0000_00FF, 32'h0000_0001, hs, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_handshake: got timeout expected ready"); end
      recv(rok, at, id, s, co, ov);
      n_checks++; if (!rok) begin n_fail++; $display("FAIL basic_resp: got timeout expected resp_valid"); end
      n_checks++; if (at - hs != NB + 1) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", at - hs, NB + 1); end
      n_checks++; if (s !== 32'h0000_0100) begin n_fail++; $display("FAIL basic_sum: got %h expected 00000100", s); end
      n_checks++; if (co !== 1'b0) begin n_fail++; $display("FAIL basic_cout: got %b expected 0", co); end
      n_checks++; if (id !== 1'b0) begin n_fail++; $display("FAIL basic_id: got %b expected 0", id); end
   endtask

   task automatic test_carry_ripple();
      int hs, at; bit ok, rok; logic id, co, ov; logic [W-1:0] s;
      send(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, hs, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL carry_handshake: got timeout expected ready"); end
      recv(rok, at, id, s, co, ov);
      n_checks++; if (!rok) begin n_fail++; $display("FAIL carry_resp: got timeout expected resp_valid"); end
      n_checks++; if (s !== 32'h0000_0000) begin n_fail++; $display("FAIL carry_sum: got %h expected 00000000", s); end
      n_checks++; if (co !== 1'b1) begin n_fail++; $display("FAIL carry_cout: got %b expected 1", co); end
      n_checks++; if (id !== 1'b1) begin n_fail++; $display("FAIL carry_id: got %b expected 1", id); end
`ifdef ADD_SEQ_OVF_EN
      n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL carry_ovf: got %b expected 0", ov); end
`endif
   endtask

   task automatic test_round_robin();
      op_t q[$]; op_t o; int last_hs; int n_hs; logic exp_g; bit hs_now; logic [W:0] e;
      last_hs = -1; n_hs = 0; exp_g = 1'b0;
      @(negedge clk);
      resp_ready = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
      for (int c = 0; c < 40; c++) begin
         #1;
         hs_now = 1'b0;
         if (resp_valid === 1'b1) begin
            n_checks++;
            if (q.size() == 0) begin
               n_fail++; $display("FAIL rr_spurious_resp: got resp_valid=1 expected 0");
            end else begin
               o = q.pop_front();
               e = ref_add(o.a, o.b);
               if (resp_sum !== e[W-1:0] || resp_cout !== e[W] || resp_id !== o.id) begin
                  n_fail++;
                  $display("FAIL rr_resp: got id=%b sum=%h cout=%b expected id=%b sum=%h cout=%b",
                           resp_id, resp_sum, resp_cout, o.id, e[W-1:0], e[W]);
               end
               $display("txn rr resp id=%0d sum=%h", resp_id, resp_sum);
            end
         end
         if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
            exp_g = ~mdl_last;
            n_checks++; if ({req1_ready, req0_ready} !== {exp_g, ~exp_g}) begin n_fail++; $display("FAIL rr_grant: got %b expected %b", {req1_ready, req0_ready}, {exp_g, ~exp_g}); end
            if (last_hs >= 0) begin
               n_checks++; if (cyc - last_hs != NB + 2) begin n_fail++; $display("FAIL rr_spacing: got %0d expected %0d", cyc - last_hs, NB + 2); end
            end
            o.id = exp_g;
            o.a  = exp_g ? req1_a : req0_a;
            o.b  = exp_g ? req1_b : req0_b;
            q.push_back(o);
            mdl_last = exp_g;
            last_hs = cyc;
            n_hs++;
            hs_now = 1'b1;
         end
         @(posedge clk);
         #1;
         if (hs_now) begin
            if (exp_g) begin req1_a = $urandom; req1_b = $urandom; end
            else begin req0_a = $urandom; req0_b = $urandom; end
         end
         @(negedge clk);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (resp_valid === 1'b1 && q.size() != 0) begin
            o = q.pop_front();
            e = ref_add(o.a, o.b);
            n_checks++;
            if (resp_sum !== e[W-1:0] || resp_id !== o.id) begin
               n_fail++; $display("FAIL rr_drain: got id=%b sum=%h expected id=%b sum=%h", resp_id, resp_sum, o.id, e[W-1:0]);
            end
         end
         @(negedge clk);
      end
      resp_ready = 1'b0;
      n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rr_outstanding: got %0d expected 0", q.size()); end
      n_checks++; if (n_hs < 6) begin n_fail++; $display("FAIL rr_count: got %0d expected >=6", n_hs); end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] a, b, a2, b2, s; logic [W:0] e, e2; int hs, hs2, at; bit ok, rok, seen; logic id, co, ov;
      a = $urandom; b = $urandom; e = ref_add(a, b);
      a2 = $urandom; b2 = $urandom; e2 = ref_add(a2, b2);
      send(1'b0, a, b, hs, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_handshake: got timeout expected ready"); end
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         if (resp_valid === 1'b1) begin seen = 1'b1; break; end
      end
      n_checks++; if (!seen) begin n_fail++; $display("FAIL bp_resp: got timeout expected resp_valid"); end
      req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom;
      req1_valid = 1'b1; req1_a = a2; req1_b = b2;
      #1;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin @(negedge clk); #1; end
         n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_hold: got %b expected 1", resp_valid); end
         n_checks++; if (resp_sum !== e[W-1:0]) begin n_fail++; $display("FAIL bp_sum_hold: got %h expected %h", resp_sum, e[W-1:0]); end
         n_checks++; if (resp_cout !== e[W] || resp_id !== 1'b0) begin n_fail++; $display("FAIL bp_cout_id_hold: got %b/%b expected %b/0", resp_cout, resp_id, e[W]); end
         n_checks++; if ({req1_ready, req0_ready} !== 2'b00) begin n_fail++; $display("FAIL bp_ready_low: got %b expected 00", {req1_ready, req0_ready}); end
         if (k == 3) resp_ready = 1'b1;
      end
      @(negedge clk); #1;
      resp_ready = 1'b0;
      hs2 = cyc;
      n_checks++; if ({req1_ready, req0_ready} !== 2'b10) begin n_fail++; $display("FAIL bp_next_grant: got %b expected 10", {req1_ready, req0_ready}); end
      mdl_last = 1'b1;
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req1_a = $urandom; req1_b = $urandom;
      recv(rok, at, id, s, co, ov);
      n_checks++; if (!rok || at - hs2 != NB + 1) begin n_fail++; $display("FAIL bp_second_latency: got %0d expected %0d", at - hs2, NB + 1); end
      n_checks++; if (s !== e2[W-1:0] || co !== e2[W] || id !== 1'b1) begin n_fail++; $display("FAIL bp_second_resp: got %h/%b/%b expected %h/%b/1", s, co, id, e2[W-1:0], e2[W]); end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] a3, b3, s; logic [W:0] e3; int hs, hs3, at; bit ok, rok; logic id, co, ov;
      a3 = $urandom; b3 = $urandom; e3 = ref_add(a3, b3);
      send(1'b1, $urandom, $urandom, hs, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rmid_handshake: got timeout expected ready"); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      req0_valid = 1'b1; req0_a = a3; req0_b = b3;
      req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom;
      @(negedge clk);
      rst = 1'b0;
      #1;
      hs3 = cyc;
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_resp_valid: got %b expected 0", resp_valid); end
      n_checks++; if (resp_sum !== '0 || resp_cout !== 1'b0 || resp_id !== 1'b0) begin n_fail++; $display("FAIL rmid_resp_cleared: got %h/%b/%b expected 0/0/0", resp_sum, resp_cout, resp_id); end
      n_checks++; if ({req1_ready, req0_ready} !== 2'b01) begin n_fail++; $display("FAIL rmid_first_tie: got %b expected 01", {req1_ready, req0_ready}); end
      mdl_last = 1'b0;
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = $urandom; req0_b = $urandom;
      recv(rok, at, id, s, co, ov);
      n_checks++; if (!rok || at - hs3 != NB + 1) begin n_fail++; $display("FAIL rmid_latency: got %0d expected %0d", at - hs3, NB + 1); end
      n_checks++; if (s !== e3[W-1:0] || co !== e3[W] || id !== 1'b0) begin n_fail++; $display("FAIL rmid_resp: got %h/%b/%b expected %h/%b/0", s, co, id, e3[W-1:0], e3[W]); end
   endtask

`ifdef ADD_SEQ_OVF_EN
   task automatic test_ovf();
      int hs, at; bit ok, rok; logic id, co, ov; logic [W-1:0] s;
      send(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, hs, ok);
      recv(rok, at, id, s, co, ov);
      n_checks++; if (!ok || !rok) begin n_fail++; $display("FAIL ovf1_txn: got timeout expected response"); end
      n_checks++; if (s !== 32'h8000_0000 || co !== 1'b0) begin n_fail++; $display("FAIL ovf1_sum: got %h/%b expected 80000000/0", s, co); end
      n_checks++; if (ov !== 1'b1) begin n_fail++; $display("FAIL ovf1_flag: got %b expected 1", ov); end
      send(1'b1, 32'h8000_0000, 32'h8000_0000, hs, ok);
      recv(rok, at, id, s, co, ov);
      n_checks++; if (!ok || !rok) begin n_fail++; $display("FAIL ovf2_txn: got timeout expected response"); end
      n_checks++; if (s !== 32'h0000_0000 || co !== 1'b1) begin n_fail++; $display("FAIL ovf2_sum: got %h/%b expected 00000000/1", s, co); end
      n_checks++; if (ov !== 1'b1) begin n_fail++; $display("FAIL ovf2_flag: got %b expected 1", ov); end
   endtask
`endif

   task automatic test_random();
      op_t pend; bit busy; int hs; logic v0, v1, exp_r0, exp_r1, exp_v; logic [W:0] e;
      do_reset();
      busy = 1'b0; hs = 0;
      pend.id = 1'b0; pend.a = '0; pend.b = '0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         v0 = 1'($urandom_range(0, 1));
         v1 = 1'($urandom_range(0, 1));
         req0_valid = v0; req1_valid = v1;
         req0_a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
         req0_b = $urandom;
         req1_a = $urandom;
         req1_b = ($urandom_range(0, 3) == 0) ? 32'h0000_0001 : $urandom;
         resp_ready = ($urandom_range(0, 2) != 0);
         #1;
         exp_r0 = !busy && v0 && (!v1 ||  mdl_last);
         exp_r1 = !busy && v1 && (!v0 || !mdl_last);
         n_checks++; if ({req1_ready, req0_ready} !== {exp_r1, exp_r0}) begin n_fail++; $display("FAIL rnd_ready cyc %0d: got %b expected %b", cyc, {req1_ready, req0_ready}, {exp_r1, exp_r0}); end
         exp_v = busy && (cyc - hs >= NB + 1);
         n_checks++; if (resp_valid !== exp_v) begin n_fail++; $display("FAIL rnd_resp_valid cyc %0d: got %b expected %b", cyc, resp_valid, exp_v); end
         if (exp_v) begin
            e = ref_add(pend.a, pend.b);
            n_checks++;
            if (resp_sum !== e[W-1:0] || resp_cout !== e[W] || resp_id !== pend.id) begin
               n_fail++;
               $display("FAIL rnd_resp cyc %0d: got id=%b sum=%h cout=%b expected id=%b sum=%h cout=%b",
                        cyc, resp_id, resp_sum, resp_cout, pend.id, e[W-1:0], e[W]);
            end
`ifdef ADD_SEQ_OVF_EN
            n_checks++; if (resp_ovf !== ref_ovf(pend.a, pend.b)) begin n_fail++; $display("FAIL rnd_ovf: got %b expected %b", resp_ovf, ref_ovf(pend.a, pend.b)); end
`endif
            if (resp_ready) begin
               busy = 1'b0;
               $display("txn rnd resp id=%0d sum=%h cout=%0d", pend.id, e[W-1:0], e[W]);
            end
         end
         if (exp_r0 || exp_r1) begin
            busy = 1'b1;
            hs = cyc;
            pend.id = exp_r1;
            pend.a = exp_r1 ? req1_a : req0_a;
            pend.b = exp_r1 ? req1_b : req0_b;
            mdl_last = exp_r1;
         end
      end
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry_ripple();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
`ifdef ADD_SEQ_OVF_EN
      test_ovf();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
